pacman_soc_usb_out_pio: RTL and testbench

Avalon-MM slave output PIO that drives control lines toward the USB controller (e.g. USB reset, wakeup) from the CPU. It is the write-side counterpart to the USB input-status PIOs already in the SoC. Software can write the output register directly, set or clear individual bits atomically, or fire self-clearing pulses of fixed length. Sits on the Platform Designer Avalon-MM fabric in the clk domain.

---
 rtl/pacman_soc_usb_out_pio_pkg.sv | 18 +
 rtl/pacman_soc_pio_pulse_timer.sv | 71 +++++++
 rtl/pacman_soc_usb_out_pio.sv | 94 +++++++++
 tb/tb_pacman_soc_usb_out_pio.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_soc_usb_out_pio_pkg.sv
// Shared definitions for the USB output PIO: register word addresses and
// the pulse engine state encoding.
package pacman_soc_usb_out_pio_pkg;

  // Register map (word addresses on the Avalon-MM slave).
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_PULSE    = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  // Pulse engine state. IDLE: no pulse bits driven. ACTIVE: a mask is
  // being held high while the counter runs down.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pacman_soc_pio_pulse_timer.sv
// Self-clearing pulse engine. A fire with a nonzero mask raises those bits
// for exactly PULSE_CYCLES clock cycles. Firing again while a pulse runs
// ORs the new mask in and restarts the full length for all held bits.
// The current state is exported so checkers can observe the FSM directly.
module pacman_soc_pio_pulse_timer
  import pacman_soc_usb_out_pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pulse_active,
  output pulse_state_t     state
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  // Counter is loaded with PULSE_CYCLES-1 on the fire edge; the bits stay
  // high through the cycle where it reads zero and drop on the next edge.
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

  pulse_state_t     r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mask;
  logic             w_mask_nonzero;

  assign w_mask_nonzero = |mask;

  // Pulse FSM: state, countdown and held mask all update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A zero mask would start a pulse that drives nothing; ignore it.
          if (fire && w_mask_nonzero) begin
            r_mask  <= mask;
            r_cnt   <= CNT_LOAD;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (fire) begin
            // Retrigger wins over expiry when both land on the same edge.
            r_mask <= r_mask | mask;
            r_cnt  <= CNT_LOAD;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_mask  <= '0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_mask  <= '0;
        end
      endcase
    end
  end

  assign pulse_active = r_mask;
  assign state        = r_state;

endmodule

// File: rtl/pacman_soc_usb_out_pio.sv
// Avalon-MM output PIO driving USB controller control lines (reset,
// wakeup, ...). Software can write the output word, atomically set or
// clear bits, or fire fixed-length self-clearing pulses.
//
// Bus handshake: a write is accepted in any cycle where chipselect=1 and
// write_n=0 and takes effect on that rising edge; there is no waitrequest,
// so the slave is always ready. Reads need no strobe: readdata is
// re-registered every cycle from the current address, so the value for an
// address appears one cycle after the address is presented.
module pacman_soc_usb_out_pio
  import pacman_soc_usb_out_pio_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] r_data;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic             w_fire;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_pulse_active;
  pulse_state_t     w_pulse_state;
  logic [WIDTH-1:0] w_rd_mux;
  logic             w_unused_wdata;

  assign w_wr    = chipselect & ~write_n;
  assign w_fire  = w_wr && (address == ADDR_PULSE);
  // Bits above WIDTH are dropped; fold them into one sink so they are
  // visibly consumed rather than silently dangling.
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  // Output data register: direct write, atomic set, atomic clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data <= w_wdata;
        ADDR_OUTSET:   r_data <= r_data | w_wdata;
        ADDR_OUTCLEAR: r_data <= r_data & ~w_wdata;
        default:       r_data <= r_data;
      endcase
    end
  end

  pacman_soc_pio_pulse_timer #(
    .WIDTH        (WIDTH),
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_timer (
    .clk          (clk),
    .reset        (reset),
    .fire         (w_fire),
    .mask         (w_wdata),
    .pulse_active (w_pulse_active),
    .state        (w_pulse_state)
  );

  // Read mux; the PULSE word reports the mask only while a pulse runs.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:  w_rd_mux = r_data;
      ADDR_PULSE: w_rd_mux = (w_pulse_state == ACTIVE) ? w_pulse_active : '0;
      default:    w_rd_mux = '0;
    endcase
  end

  // Readdata is captured every cycle and zero-extended to the bus width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= 32'(w_rd_mux);
    end
  end

  assign readdata = r_readdata;
  // Driven only from registers, so bus activity cannot glitch the lines.
  assign out_port = r_data | w_pulse_active;

endmodule

// File: tb/tb_pacman_soc_usb_out_pio.sv
// Bench for the USB output PIO: directed register/pulse scenarios plus a
// randomized bus run checked against a time-based reference model.
module tb_pacman_soc_usb_out_pio;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         PC    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: output word, pulse mask, and the edge number at which
  // the pulse mask expires.
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  int          m_end;
  int          k = 0;
  logic [31:0] m_rd;

  pacman_soc_usb_out_pio #(
    .WIDTH        (WIDTH),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [7:0] m_out();
    return m_data | m_mask;
  endfunction

  task automatic model_reset();
    m_data = RV;
    m_mask = '0;
    m_end  = 0;
    m_rd   = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // let the DUT take that edge and settle.
  task automatic tick();
    logic        wr;
    logic [7:0]  wm;
    logic [31:0] nrd;
    logic        active_before;
    wr = chipselect && !write_n;
    wm = writedata[7:0];
    case (address)
      2'd0:    nrd = {24'h0, m_data};
      2'd1:    nrd = {24'h0, m_mask};
      default: nrd = '0;
    endcase
    k++;
    active_before = (m_mask != 8'h00);
    if (wr && address == 2'd1 && (active_before || wm != 8'h00)) begin
      m_mask = m_mask | wm;
      m_end  = k + PC;
    end else if (active_before && k >= m_end) begin
      m_mask = '0;
    end
    if (wr) begin
      case (address)
        2'd0:    m_data = wm;
        2'd2:    m_data = m_data | wm;
        2'd3:    m_data = m_data & ~wm;
        default: m_data = m_data;
      endcase
    end
    m_rd = nrd;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = $urandom;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    address = 2'd0;
    bus_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (out_port !== 8'hA5) begin
      n_fail++; $display("FAIL reset_out_port: got %h expected %h", out_port, 8'hA5);
    end
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    reset = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (readdata !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL reset_read_data: got %h expected %h", readdata, 32'h0000_00A5);
    end
  endtask

  task automatic test_data_write();
    bus_write(2'd0, 32'hFFFF_FF3C);
    n_checks++;
    if (out_port !== 8'h3C) begin
      n_fail++; $display("FAIL data_write_out: got %h expected %h", out_port, 8'h3C);
    end
    tick();
    n_checks++;
    if (readdata !== 32'h0000_003C) begin
      n_fail++; $display("FAIL data_write_read: got %h expected %h", readdata, 32'h0000_003C);
    end
    // Writes without chipselect, or with write_n high, are ignored.
    chipselect = 1'b0; write_n = 1'b0; writedata = 32'hFF;
    tick();
    chipselect = 1'b1; write_n = 1'b1; writedata = 32'h00;
    tick();
    bus_idle();
    n_checks++;
    if (out_port !== 8'h3C) begin
      n_fail++; $display("FAIL data_write_ignored: got %h expected %h", out_port, 8'h3C);
    end
  endtask

  task automatic test_set_clear();
    bus_write(2'd2, 32'h0000_0081);
    n_checks++;
    if (out_port !== 8'hBD) begin
      n_fail++; $display("FAIL outset: got %h expected %h", out_port, 8'hBD);
    end
    bus_write(2'd3, 32'h0000_000C);
    n_checks++;
    if (out_port !== 8'hB1) begin
      n_fail++; $display("FAIL outclear: got %h expected %h", out_port, 8'hB1);
    end
    tick();
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL read_outclear: got %h expected %h", readdata, 32'h0);
    end
    address = 2'd2;
    tick();
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL read_outset: got %h expected %h", readdata, 32'h0);
    end
    address = 2'd0;
    tick();
    n_checks++;
    if (readdata !== 32'h0000_00B1) begin
      n_fail++; $display("FAIL read_after_setclear: got %h expected %h", readdata, 32'h0000_00B1);
    end
  endtask

  task automatic test_pulse();
    int cnt;
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h0000_0001);
    cnt = out_port[0] ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (out_port[0]) cnt++;
      if (i == 1) begin
        n_checks++;
        if (readdata !== 32'h1) begin
          n_fail++; $display("FAIL pulse_read_active: got %h expected %h", readdata, 32'h1);
        end
      end
    end
    n_checks++;
    if (cnt != PC) begin
      n_fail++; $display("FAIL pulse_length: got %0d expected %0d", cnt, PC);
    end
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL pulse_read_idle: got %h expected %h", readdata, 32'h0);
    end
    n_checks++;
    if (out_port !== 8'h00) begin
      n_fail++; $display("FAIL pulse_end_out: got %h expected %h", out_port, 8'h00);
    end
  endtask

  task automatic test_retrigger();
    int c0, c1, c2, last0, last1;
    // Second pulse two cycles into the first.
    c0 = 0; c1 = 0; last0 = -1; last1 = -1;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) bus_write(2'd1, 32'h1);
      else if (i == 2) bus_write(2'd1, 32'h2);
      else tick();
      if (out_port[0]) begin c0++; last0 = i; end
      if (out_port[1]) begin c1++; last1 = i; end
    end
    n_checks++;
    if (c0 != 6) begin
      n_fail++; $display("FAIL retrig_bit0_len: got %0d expected %0d", c0, 6);
    end
    n_checks++;
    if (c1 != 4) begin
      n_fail++; $display("FAIL retrig_bit1_len: got %0d expected %0d", c1, 4);
    end
    n_checks++;
    if (last0 != last1) begin
      n_fail++; $display("FAIL retrig_fall_together: got %0d expected %0d", last0, last1);
    end
    // Retrigger landing exactly on the expiry edge.
    c0 = 0; c2 = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) bus_write(2'd1, 32'h1);
      else if (i == PC) bus_write(2'd1, 32'h4);
      else tick();
      if (out_port[0]) c0++;
      if (out_port[2]) c2++;
    end
    n_checks++;
    if (c0 != 2 * PC) begin
      n_fail++; $display("FAIL expiry_retrig_bit0: got %0d expected %0d", c0, 2 * PC);
    end
    n_checks++;
    if (c2 != PC) begin
      n_fail++; $display("FAIL expiry_retrig_bit2: got %0d expected %0d", c2, PC);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int bad;
    bus_write(2'd0, 32'h10);
    bus_write(2'd1, 32'h1);
    tick();
    n_checks++;
    if (out_port !== 8'h11) begin
      n_fail++; $display("FAIL midpulse_before: got %h expected %h", out_port, 8'h11);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_port !== RV) begin
      n_fail++; $display("FAIL midpulse_async_out: got %h expected %h", out_port, RV);
    end
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL midpulse_async_rd: got %h expected %h", readdata, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    address = 2'd1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_port !== RV) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midpulse_no_resume: got %0d bad cycles expected %0d", bad, 0);
    end
    n_checks++;
    if (readdata !== 32'h0) begin
      n_fail++; $display("FAIL midpulse_pulse_read: got %h expected %h", readdata, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = $urandom_range(0, 1) == 1;
      address    = 2'($urandom_range(0, 3));
      writedata  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FF00) : $urandom;
      tick();
      n_checks++;
      if (out_port !== m_out()) begin
        n_fail++; $display("FAIL random_out cycle %0d: got %h expected %h", i, out_port, m_out());
      end
      n_checks++;
      if (readdata !== m_rd) begin
        n_fail++; $display("FAIL random_rd cycle %0d: got %h expected %h", i, readdata, m_rd);
      end
    end
    bus_idle();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_data_write();
    test_set_clear();
    test_pulse();
    test_retrigger();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
